// File: rtl/lzc_int2fp_normalizer_if.sv
// Handshake bundle between the LZC front end, the int-to-float normalizer and the FP datapath.
// The slave modport is the normalizer side; the master modport drives operands and consumes results.
interface lzc_int2fp_normalizer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] Din;
  logic [CNT_W-1:0]  Lz;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       Dout;
  logic              inexact;

  modport slave (
    input  in_valid, Din, Lz, out_ready,
    output in_ready, out_valid, Dout, inexact
  );

  modport master (
    output in_valid, Din, Lz, out_ready,
    input  in_ready, out_valid, Dout, inexact
  );
endinterface

// File: rtl/lzc_int2fp_normalizer.sv
// Unsigned 32-bit integer + leading-zero count -> IEEE-754 single, 2-stage valid/ready pipeline.
// Define LZC_NORM_ROUND_EN for round-to-nearest-even; otherwise the fraction is truncated.
module lzc_int2fp_normalizer #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 6,
  parameter int MAN_W    = 23,
  parameter int EXP_W    = 8,
  parameter int EXP_BIAS = 127
) (
  input logic clk,
  input logic rst_n,
  lzc_int2fp_normalizer_if.slave bus
);
  localparam int E_W = $clog2(DATA_W);

  logic              v1;
  logic              zero1;
  logic [DATA_W-2:0] sh1;
  logic [E_W-1:0]    e1;
  logic              v2;
  logic [31:0]       dout_q;
  logic              inexact_q;

  logic              adv1;
  logic              adv2;
  logic              zero_next;
  logic [DATA_W-2:0] sh_next;
  logic [E_W-1:0]    e_next;

  logic [MAN_W-1:0]  frac;
  logic [MAN_W-1:0]  frac_r;
  logic              g_bit;
  logic              s_bit;
  logic              carry;
  logic [EXP_W-1:0]  exp_field;
  logic [31:0]       dout_next;
  logic              inexact_next;

  assign adv2         = !v2 || bus.out_ready;
  assign adv1         = !v1 || adv2;
  assign bus.in_ready = adv1;
  assign bus.out_valid = v2;
  assign bus.Dout      = dout_q;
  assign bus.inexact   = inexact_q;

  // The leading one is shifted out of bit 31 and becomes the implicit bit, so only 31 bits are kept.
  always_comb begin
    zero_next = (bus.Lz >= CNT_W'(DATA_W));
    sh_next   = zero_next ? '0 : (DATA_W-1)'(bus.Din << bus.Lz);
    e_next    = E_W'(DATA_W-1) - bus.Lz[E_W-1:0];
  end

  always_comb begin
    frac  = sh1[DATA_W-2 -: MAN_W];
    g_bit = sh1[DATA_W-2-MAN_W];
    s_bit = |sh1[DATA_W-3-MAN_W:0];
`ifdef LZC_NORM_ROUND_EN
    begin
      logic             l_bit;
      logic             up;
      logic [MAN_W:0]   sum;
      l_bit  = sh1[DATA_W-1-MAN_W];
      up     = g_bit && (s_bit || l_bit);
      sum    = {1'b0, frac} + {{MAN_W{1'b0}}, up};
      carry  = sum[MAN_W];
      // On carry-out the fraction wraps to zero and the exponent absorbs the carry.
      frac_r = sum[MAN_W-1:0];
    end
`else
    carry  = 1'b0;
    frac_r = frac;
`endif
    // Modulo-2^EXP_W add matches a 9-bit sum truncated to EXP_W.
    exp_field    = EXP_W'(e1) + EXP_W'(EXP_BIAS) + EXP_W'(carry);
    dout_next    = zero1 ? 32'h0 : {1'b0, exp_field, frac_r};
    inexact_next = zero1 ? 1'b0 : (g_bit || s_bit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      zero1 <= 1'b0;
      sh1   <= '0;
      e1    <= '0;
    end else if (adv1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        zero1 <= zero_next;
        sh1   <= sh_next;
        e1    <= e_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      dout_q    <= 32'h0;
      inexact_q <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        dout_q    <= dout_next;
        inexact_q <= inexact_next;
      end
    end
  end
endmodule

// File: tb/tb_lzc_int2fp_normalizer.sv
// Self-checking bench: directed test-plan vectors, backpressure, async reset and randomized
// traffic scored against an arithmetic int-to-float reference model.
module tb_lzc_int2fp_normalizer;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  lzc_int2fp_normalizer_if #(.DATA_W(32), .CNT_W(6)) bus ();

  lzc_int2fp_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] clz(input logic [31:0] d);
    int n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i]) break;
      n++;
    end
    return 6'(n);
  endfunction

  // Returns {inexact, float bits}, derived from the value of d rather than bit slicing.
  function automatic logic [32:0] ref_fp(input logic [31:0] d);
    int              p;
    int              e;
    int              r;
    longint unsigned m;
    longint unsigned rem;
    longint unsigned half;
    logic            inx;
    if (d == 32'h0) return 33'h0;
    p = 31;
    while (d[p] == 1'b0) p--;
    e   = p + 127;
    inx = 1'b0;
    if (p <= 23) begin
      m = longint'(d) << (23 - p);
    end else begin
      r    = p - 23;
      m    = longint'(d) >> r;
      rem  = longint'(d) & ((64'd1 << r) - 64'd1);
      half = 64'd1 << (r - 1);
      inx  = (rem != 0);
`ifdef LZC_NORM_ROUND_EN
      if (rem > half || (rem == half && m[0])) m = m + 1;
      if (m == (64'd1 << 24)) begin
        m = m >> 1;
        e = e + 1;
      end
`endif
    end
    return {inx, 1'b0, 8'(e), 23'(m)};
  endfunction

  task automatic directed(input string tag, input logic [31:0] d, input logic [5:0] lz,
                          input logic [32:0] exp);
    bus.in_valid  = 1'b1;
    bus.Din       = d;
    bus.Lz        = lz;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, {32'h0, bus.in_ready}, 33'h1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, {32'h0, bus.out_valid}, 33'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_lat2"}, {32'h0, bus.out_valid}, 33'h1);
    check(tag, {bus.inexact, bus.Dout}, exp);
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_exp [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

  initial begin
    int idx;
    int got;
    logic [31:0] d;
    logic [32:0] fp_ff;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.Din       = '0;
    bus.Lz        = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {32'h0, bus.out_valid}, 33'h0);
    check("rst_dout", {bus.inexact, bus.Dout}, 33'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {32'h0, bus.in_ready}, 33'h1);
    @(posedge clk); #1;

`ifdef LZC_NORM_ROUND_EN
    fp_ff = {1'b1, 32'h4F800000};
`else
    fp_ff = {1'b1, 32'h4F7FFFFF};
`endif
    directed("one",  32'h00000001, 6'd31, {1'b0, 32'h3F800000});
    directed("msb",  32'h80000000, 6'd0,  {1'b0, 32'h4F000000});
    directed("ones", 32'hFFFFFFFF, 6'd0,  fp_ff);
    directed("tie",  32'h01000001, 6'd7,  {1'b1, 32'h4B800000});
    directed("zero", 32'h00000000, 6'd32, {1'b0, 32'h00000000});

    // Backpressure: four back-to-back operands against a stalled sink.
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (idx < 4);
      bus.Din       = 32'(idx + 1);
      bus.Lz        = clz(32'(idx + 1));
      @(negedge clk);
      if (cyc == 2) check("bp_stall", {32'h0, bus.in_ready}, 33'h0);
      if (cyc == 4) check("bp_accepts", 33'(idx), 33'd2);
      if (bus.out_valid && bus.out_ready) begin
        if (got < 4) check("bp_out", {1'b0, bus.Dout}, {1'b0, bp_exp[got]});
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("bp_count", 33'(got), 33'd4);

    // Asynchronous reset with both stages full.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.Din      = 32'h1234 << k;
      bus.Lz       = clz(32'h1234 << k);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("full_before_rst", {32'h0, bus.out_valid}, 33'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {32'h0, bus.out_valid}, 33'h0);
    check("async_rst_dout", {bus.inexact, bus.Dout}, 33'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_valid", {32'h0, bus.out_valid}, 33'h0);
      check("post_rst_ready", {32'h0, bus.in_ready}, 33'h1);
      @(posedge clk); #1;
    end

    // Randomized traffic against the reference model.
    exp_q.delete();
    d = $urandom;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!bus.in_valid || bus.in_ready) begin
        case ($urandom_range(0, 3))
          0: d = $urandom;
          1: d = $urandom >> $urandom_range(0, 31);
          2: d = (32'h1 << $urandom_range(0, 31)) | ($urandom & 32'h1FF);
          default: d = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom | 32'h80000000);
        endcase
        bus.in_valid = ($urandom_range(0, 9) < 7);
        bus.Din      = d;
        bus.Lz       = clz(d);
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("rnd_spurious", {32'h0, bus.out_valid}, 33'h0);
        else begin
          check("rnd_out", {bus.inexact, bus.Dout}, exp_q[0]);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_fp(bus.Din));
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) check("drain_spurious", {32'h0, bus.out_valid}, 33'h0);
        else check("drain_out", {bus.inexact, bus.Dout}, exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
    check("drain_empty", 33'(exp_q.size()), 33'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/lzc_int2fp_normalizer.md
Name: lzc_int2fp_normalizer

Overview:
- Downstream consumer of the 32-bit leading-zero counter.
- Takes an unsigned 32-bit integer plus its leading-zero count and produces an IEEE-754 single-precision encoding: normalize by left shift, then round and pack exponent.
- 2-stage pipeline with valid/ready handshakes on both sides. Sits between the LZC front end and the FP datapath.

Parameters:
- DATA_W, 32, integer input width; fixed by the LZC upstream.
- CNT_W, 6, width of the leading-zero count; holds 0..32.
- MAN_W, 23, stored fraction width.
- EXP_W, 8, exponent field width.
- EXP_BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock; all state rises on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  Din/Lz valid this cycle.
- in_ready  out  1  block accepts Din/Lz this cycle.
- Din  in  DATA_W  unsigned integer operand.
- Lz  in  CNT_W  leading-zero count of Din from the LZC, 0..32.
- out_valid  out  1  Dout/inexact valid.
- out_ready  in  1  downstream accepts Dout.
- Dout  out  32  packed float {sign=0, exp[EXP_W], frac[MAN_W]}.
- inexact  out  1  nonzero bits were discarded by rounding or truncation.

Behaviour:
- **Reset (async on rst_n low, any time, including mid-transfer):** v1 = v2 = 0, out_valid = 0, Dout = 0, inexact = 0. All in-flight data is dropped. in_ready = 1 from the first cycle after release.
- **Handshake:**
  - Transfer in when in_valid & in_ready.
  - Transfer out when out_valid & out_ready.
  - Once out_valid is asserted, Dout and inexact hold stable until accepted.
- **Flow control:**
  - adv2 = !v2 | out_ready.
  - adv1 = !v1 | adv2.
  - in_ready = adv1; combinational from out_ready, no registered bubble.
  - Full throughput of 1 op/cycle when out_ready stays high.
- **Latency:** 2 cycles. An input accepted at edge N appears with out_valid at edge N+2 when no stall occurs.
- **Stage 1 (normalize), registered on in transfer:**
  - zero1 = (Lz >= 32).
  - sh1 = Din << Lz (32 bits); forced to 0 when zero1.
  - e1 = 31 - Lz.
  - Lz is trusted; no consistency check against Din.
- **Stage 2 (round/pack), registered when adv2 & v1:**
  - frac = sh1[30:8], G = sh1[7], S = |sh1[6:0], L = sh1[8].
  - Round-to-nearest-even: up = G & (S | L).
  - {c, frac'} = frac + up.
  - exp = e1 + EXP_BIAS + c; if c = 1, frac' = 0.
  - Dout = {1'b0, exp[7:0], frac'}.
  - inexact = G | S.
  - zero1 gives Dout = 0x00000000, inexact = 0.
- **Width and range rules:**
  - Lz = 31 (Din = 1) gives exp 127.
  - Lz = 0 gives exp 158; the maximum after round carry is 159.
  - No overflow, subnormal or negative cases exist.
  - The bias is added in 9-bit arithmetic and truncated to EXP_W.
- **Simultaneous events:**
  - If stage 2 drains and stage 1 refills in the same cycle, both happen.
  - If in and out transfers occur in the same cycle while full, occupancy is unchanged.
- Ordering is strictly FIFO; no output is duplicated or dropped under any out_ready pattern.
- When out_valid = 0, Dout and inexact hold their last value; they are don't-care for the checker.

Optional Feature:
- Macro: LZC_NORM_ROUND_EN.
- Defined: round-to-nearest-even as in stage 2; inexact = G | S.
- Undefined:
  - Truncation: up = 0, c = 0, frac' = frac.
  - inexact still reports G | S.
  - Rounding adder and carry logic are removed.
- Latency and handshake are identical in both builds.

Test Plan:
- Din=0x00000001, Lz=31, out_ready=1 → out_valid 2 cycles later, Dout=0x3F800000, inexact=0.
- Din=0x80000000, Lz=0 → Dout=0x4F000000, inexact=0.
- Din=0xFFFFFFFF, Lz=0:
  - LZC_NORM_ROUND_EN defined → Dout=0x4F800000, inexact=1.
  - Macro undefined → Dout=0x4F7FFFFF, inexact=1.
- Din=0x01000001, Lz=7 (tie case, even LSB) → Dout=0x4B800000, inexact=1. Din=0x00000000, Lz=32 → Dout=0x00000000, inexact=0.
- Backpressure: 4 back-to-back inputs (1, 2, 3, 4 with matching Lz), out_ready=0 for 5 cycles:
  - in_ready drops after 2 accepts.
  - Outputs 0x3F800000, 0x40000000, 0x40400000, 0x40800000 appear in order once out_ready=1, with none lost.
- rst_n pulsed low mid-stream with both stages full → out_valid=0 immediately (asynchronous). After release, in_ready=1 and no stale result is emitted.
